// File: rtl/itable_sequencer.sv
// itable_sequencer: instruction-cycle sequencer in front of the opcode decoder.
// It fetches opcode/operand bytes, holds the current opcode (ITABLE) and
// steps the execution phase counter (XPT). It also picks the next machine
// cycle from the decoder's phase-control pulses.
module itable_sequencer (
    input  logic       CLK,
    input  logic       notRESET,
    input  logic [7:0] MDATA,
    input  logic       MACK,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CMR,
    input  logic       P2_Set_CMA,
    input  logic       P2_Set_ILDlnnlHL_1,
    input  logic       P2_Set_ILDAlnnl_1,
    input  logic       P2_Set_IJPnn_1,
    output logic       enable,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] OP,
    output logic [7:0] OPOLD,
    output logic       MREQ,
    output logic [1:0] MMODE,
    output logic [1:0] IEXT,
    output logic       XPT_ERR
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_e;

    localparam logic [1:0] MMODE_M1 = 2'b00;
    localparam logic [1:0] MMODE_R  = 2'b01;
    localparam logic [1:0] MMODE_A  = 2'b10;

    state_e     state_q,   state_d;
    logic [7:0] itable_q,  itable_d;
    logic [3:0] xpt_q,     xpt_d;
    logic [7:0] op_q,      op_d;
    logic [7:0] opold_q,   opold_d;
    logic [1:0] mmode_q,   mmode_d;
    logic [1:0] iext_q,    iext_d;
    logic       xpt_err_q, xpt_err_d;

    // State and datapath registers, asynchronously cleared by notRESET.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q   <= ST_FETCH;
            itable_q  <= 8'h00;
            xpt_q     <= 4'd0;
            op_q      <= 8'h00;
            opold_q   <= 8'h00;
            mmode_q   <= MMODE_M1;
            iext_q    <= 2'b00;
            xpt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            itable_q  <= itable_d;
            xpt_q     <= xpt_d;
            op_q      <= op_d;
            opold_q   <= opold_d;
            mmode_q   <= mmode_d;
            iext_q    <= iext_d;
            xpt_err_q <= xpt_err_d;
        end
    end

    // Next-state and datapath update for the FETCH/EXEC/MEM machine cycles.
    always_comb begin
        state_d   = state_q;
        itable_d  = itable_q;
        xpt_d     = xpt_q;
        op_d      = op_q;
        opold_d   = opold_q;
        mmode_d   = mmode_q;
        iext_d    = iext_q;
        xpt_err_d = xpt_err_q;

        case (state_q)
            ST_FETCH: begin
                // Opcode fetch: wait for the memory acknowledge.
                if (MACK) begin
                    itable_d = MDATA;
                    xpt_d    = 4'd0;
                    mmode_d  = MMODE_M1;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_FETCH;
                end
            end

            ST_EXEC: begin
                if (P2_Set_CM1) begin
                    // End of instruction: flags cleared, next opcode fetched.
                    state_d = ST_FETCH;
                    xpt_d   = 4'd0;
                    iext_d  = 2'b00;
                    mmode_d = MMODE_M1;
                    if (P2_Reset_ITABLE) begin
                        itable_d = 8'h00;
                    end else begin
                        itable_d = itable_q;
                    end
                end else begin
                    // Continuation flag is recorded alongside the cycle choice.
                    if (P2_Set_IJPnn_1) begin
                        iext_d = 2'b11;
                    end else if (P2_Set_ILDAlnnl_1) begin
                        iext_d = 2'b10;
                    end else if (P2_Set_ILDlnnlHL_1) begin
                        iext_d = 2'b01;
                    end else begin
                        iext_d = iext_q;
                    end

                    // Clearing ITABLE alone makes decode continue as opcode 00.
                    if (P2_Reset_ITABLE) begin
                        itable_d = 8'h00;
                    end else begin
                        itable_d = itable_q;
                    end

                    if (P2_Set_CMR) begin
                        state_d = ST_MEM;
                        mmode_d = MMODE_R;
                    end else if (P2_Set_CMA) begin
                        state_d = ST_MEM;
                        mmode_d = MMODE_A;
                    end else if (PR_Reset_XPT) begin
                        xpt_d = 4'd0;
                    end else begin
                        xpt_d = xpt_q + 4'd1;
                        if (xpt_q == 4'd15) begin
                            xpt_err_d = 1'b1;
                        end else begin
                            xpt_err_d = xpt_err_q;
                        end
                    end
                end
            end

            ST_MEM: begin
                // Operand read or address cycle; either kind latches MDATA.
                if (MACK) begin
                    opold_d = op_q;
                    op_d    = MDATA;
                    xpt_d   = xpt_q + 4'd1;
                    mmode_d = MMODE_M1;
                    state_d = ST_EXEC;
                    if (xpt_q == 4'd15) begin
                        xpt_err_d = 1'b1;
                    end else begin
                        xpt_err_d = xpt_err_q;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // enable and MREQ decode straight from the state register.
    assign enable    = (state_q == ST_EXEC);
    assign MREQ      = (state_q != ST_EXEC);

    assign ITABLE    = itable_q;
    assign notITABLE = ~itable_q;
    assign XPT       = xpt_q;
    assign notXPT    = ~xpt_q;
    assign OP        = op_q;
    assign OPOLD     = opold_q;
    assign MMODE     = mmode_q;
    assign IEXT      = iext_q;
    assign XPT_ERR   = xpt_err_q;

endmodule

// File: tb/tb_itable_sequencer.sv
// Directed bench for itable_sequencer; decoder pulses are driven by hand.
module tb_itable_sequencer;

    logic       CLK;
    logic       notRESET;
    logic [7:0] MDATA;
    logic       MACK;
    logic       P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT;
    logic       P2_Set_CMR, P2_Set_CMA;
    logic       P2_Set_ILDlnnlHL_1, P2_Set_ILDAlnnl_1, P2_Set_IJPnn_1;
    logic       enable;
    logic [7:0] ITABLE, notITABLE, OP, OPOLD;
    logic [3:0] XPT, notXPT;
    logic       MREQ;
    logic [1:0] MMODE, IEXT;
    logic       XPT_ERR;

    int vec_cnt = 0;
    int err_cnt = 0;

    itable_sequencer dut (
        .CLK                (CLK),
        .notRESET           (notRESET),
        .MDATA              (MDATA),
        .MACK               (MACK),
        .P2_Set_CM1         (P2_Set_CM1),
        .P2_Reset_ITABLE    (P2_Reset_ITABLE),
        .PR_Reset_XPT       (PR_Reset_XPT),
        .P2_Set_CMR         (P2_Set_CMR),
        .P2_Set_CMA         (P2_Set_CMA),
        .P2_Set_ILDlnnlHL_1 (P2_Set_ILDlnnlHL_1),
        .P2_Set_ILDAlnnl_1  (P2_Set_ILDAlnnl_1),
        .P2_Set_IJPnn_1     (P2_Set_IJPnn_1),
        .enable             (enable),
        .ITABLE             (ITABLE),
        .notITABLE          (notITABLE),
        .XPT                (XPT),
        .notXPT             (notXPT),
        .OP                 (OP),
        .OPOLD              (OPOLD),
        .MREQ               (MREQ),
        .MMODE              (MMODE),
        .IEXT               (IEXT),
        .XPT_ERR            (XPT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, " ITABLE"},    32'(ITABLE),    32'h00);
        check_val({tag, " notITABLE"}, 32'(notITABLE), 32'hFF);
        check_val({tag, " XPT"},       32'(XPT),       32'h0);
        check_val({tag, " notXPT"},    32'(notXPT),    32'hF);
        check_val({tag, " OP"},        32'(OP),        32'h00);
        check_val({tag, " OPOLD"},     32'(OPOLD),     32'h00);
        check_val({tag, " MMODE"},     32'(MMODE),     32'h0);
        check_val({tag, " IEXT"},      32'(IEXT),      32'h0);
        check_val({tag, " XPT_ERR"},   32'(XPT_ERR),   32'h0);
        check_val({tag, " enable"},    32'(enable),    32'h0);
        check_val({tag, " MREQ"},      32'(MREQ),      32'h1);
    endtask

    initial begin
        notRESET = 1'b0;
        MDATA = 8'h00; MACK = 1'b0;
        P2_Set_CM1 = 1'b0; P2_Reset_ITABLE = 1'b0; PR_Reset_XPT = 1'b0;
        P2_Set_CMR = 1'b0; P2_Set_CMA = 1'b0;
        P2_Set_ILDlnnlHL_1 = 1'b0; P2_Set_ILDAlnnl_1 = 1'b0; P2_Set_IJPnn_1 = 1'b0;

        #3;
        check_reset_vals("rst");
        #20;
        notRESET = 1'b1;
        #1;

        // Minimum instruction loop: opcode 00 ends at XPT=0 every time.
        MACK = 1'b1; MDATA = 8'h00; P2_Set_CM1 = 1'b1; P2_Reset_ITABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("min fetch MREQ", 32'(MREQ), 32'h1);
            tick();
            check_val("min exec MREQ", 32'(MREQ), 32'h0);
            check_val("min exec en", 32'(enable), 32'h1);
            check_val("min ITABLE", 32'(ITABLE), 32'h00);
            check_val("min notITABLE", 32'(notITABLE), 32'hFF);
            tick();
        end
        MACK = 1'b0; P2_Set_CM1 = 1'b0; P2_Reset_ITABLE = 1'b0;

        // Fetch 0x3A with three wait cycles.
        MDATA = 8'h3A;
        for (int i = 0; i < 3; i++) begin
            check_val("wait en", 32'(enable), 32'h0);
            check_val("wait MREQ", 32'(MREQ), 32'h1);
            tick();
        end
        check_val("wait ITABLE held", 32'(ITABLE), 32'h00);
        MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("fetch ITABLE", 32'(ITABLE), 32'h3A);
        check_val("fetch notITABLE", 32'(notITABLE), 32'hC5);
        check_val("fetch en", 32'(enable), 32'h1);
        check_val("fetch XPT", 32'(XPT), 32'h0);

        // Two operand reads at XPT=2 and XPT=3.
        tick();
        tick();
        check_val("pre CMR XPT", 32'(XPT), 32'h2);
        P2_Set_CMR = 1'b1;
        tick();
        P2_Set_CMR = 1'b0;
        check_val("mem1 MREQ", 32'(MREQ), 32'h1);
        check_val("mem1 MMODE", 32'(MMODE), 32'h1);
        check_val("mem1 XPT", 32'(XPT), 32'h2);
        check_val("mem1 en", 32'(enable), 32'h0);
        MDATA = 8'h34; MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("rd1 OP", 32'(OP), 32'h34);
        check_val("rd1 XPT", 32'(XPT), 32'h3);
        P2_Set_CMR = 1'b1;
        tick();
        P2_Set_CMR = 1'b0;
        MDATA = 8'h12; MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("rd2 OP", 32'(OP), 32'h12);
        check_val("rd2 OPOLD", 32'(OPOLD), 32'h34);
        check_val("rd2 XPT", 32'(XPT), 32'h4);
        check_val("rd2 MMODE", 32'(MMODE), 32'h0);
        check_val("rd2 en", 32'(enable), 32'h1);

        // Address cycle.
        P2_Set_CMA = 1'b1;
        tick();
        P2_Set_CMA = 1'b0;
        check_val("cma MMODE", 32'(MMODE), 32'h2);
        MDATA = 8'h56; MACK = 1'b1;
        tick();
        check_val("cma OP", 32'(OP), 32'h56);
        check_val("cma OPOLD", 32'(OPOLD), 32'h12);
        check_val("cma XPT", 32'(XPT), 32'h5);

        // MACK while in EXEC is ignored; PR_Reset_XPT clears the phase.
        MDATA = 8'h99; PR_Reset_XPT = 1'b1;
        tick();
        MACK = 1'b0; PR_Reset_XPT = 1'b0;
        check_val("ign OP", 32'(OP), 32'h56);
        check_val("ign XPT", 32'(XPT), 32'h0);
        check_val("ign en", 32'(enable), 32'h1);

        // Continuation flags with CMR in the same cycle.
        P2_Set_IJPnn_1 = 1'b1; P2_Set_ILDAlnnl_1 = 1'b1; P2_Set_CMR = 1'b1;
        tick();
        P2_Set_IJPnn_1 = 1'b0; P2_Set_ILDAlnnl_1 = 1'b0; P2_Set_CMR = 1'b0;
        check_val("ext IEXT", 32'(IEXT), 32'h3);
        check_val("ext MREQ", 32'(MREQ), 32'h1);
        check_val("ext MMODE", 32'(MMODE), 32'h1);
        MDATA = 8'h77; MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("ext hold IEXT", 32'(IEXT), 32'h3);
        check_val("ext XPT", 32'(XPT), 32'h1);
        P2_Set_ILDlnnlHL_1 = 1'b1;
        tick();
        P2_Set_ILDlnnlHL_1 = 1'b0;
        check_val("hl IEXT", 32'(IEXT), 32'h1);
        check_val("hl XPT", 32'(XPT), 32'h2);
        P2_Set_CM1 = 1'b1;
        tick();
        P2_Set_CM1 = 1'b0;
        check_val("cm1 IEXT", 32'(IEXT), 32'h0);
        check_val("cm1 XPT", 32'(XPT), 32'h0);
        check_val("cm1 MREQ", 32'(MREQ), 32'h1);
        check_val("cm1 ITABLE", 32'(ITABLE), 32'h3A);

        // ITABLE cleared without ending the instruction.
        MDATA = 8'hC3; MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("c3 ITABLE", 32'(ITABLE), 32'hC3);
        P2_Reset_ITABLE = 1'b1;
        tick();
        P2_Reset_ITABLE = 1'b0;
        check_val("rstit ITABLE", 32'(ITABLE), 32'h00);
        check_val("rstit en", 32'(enable), 32'h1);

        // Phase counter wrap sets the sticky error.
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        check_val("wrap start", 32'(XPT), 32'h0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_val("wrap XPT", 32'(XPT), 32'(i));
            check_val("wrap notXPT", 32'(notXPT), 32'(15 - i));
        end
        check_val("wrap err pre", 32'(XPT_ERR), 32'h0);
        tick();
        check_val("wrap XPT0", 32'(XPT), 32'h0);
        check_val("wrap err", 32'(XPT_ERR), 32'h1);
        tick();
        tick();
        check_val("err sticky", 32'(XPT_ERR), 32'h1);

        // Asynchronous reset in the middle of a MEM cycle.
        P2_Set_CMR = 1'b1;
        tick();
        P2_Set_CMR = 1'b0;
        check_val("pre rst MREQ", 32'(MREQ), 32'h1);
        #2;
        notRESET = 1'b0;
        #1;
        check_reset_vals("async");
        notRESET = 1'b1;
        MDATA = 8'hA5; MACK = 1'b1;
        tick();
        MACK = 1'b0;
        check_val("restart ITABLE", 32'(ITABLE), 32'hA5);
        check_val("restart en", 32'(enable), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
